// File: rtl/rr_arbiter.sv
// N-requester arbiter, run-time selectable round-robin / fixed priority, with hold-limit preemption.
// Registered one-hot grant one cycle after the deciding edge; an owner keeps its grant while it keeps requesting.
module rr_arbiter #(
    parameter int N        = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic                           rr_en,
    input  logic [N-1:0]                   req,
    output logic [N-1:0]                   grant,
    output logic                           grant_valid,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  last_owner, last_owner_nxt;
    logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [N-1:0]   grant_nxt;
    logic           grant_valid_nxt;
    logic [IW-1:0]  grant_idx_nxt;
    logic [N-1:0]   others;

    // Round-robin scans cyclically starting just after the last owner.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] mask,
                                           input logic rr,
                                           input logic [IW-1:0] last);
        logic [IW-1:0] idx;
        logic          found;
        int            p;
        idx   = '0;
        found = 1'b0;
        if (rr) begin
            for (int k = 1; k <= N; k++) begin
                p = (int'(last) + k) % N;
                if (!found && mask[p]) begin
                    idx   = IW'(p);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && mask[i]) begin
                    idx   = IW'(i);
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

    assign others = req & ~grant;

    always_comb begin
        state_nxt       = state;
        last_owner_nxt  = last_owner;
        hold_cnt_nxt    = hold_cnt;
        grant_idx_nxt   = grant_idx;
        grant_valid_nxt = grant_valid;

        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt       = GRANT;
                    grant_idx_nxt   = pick(req, rr_en, last_owner);
                    grant_valid_nxt = 1'b1;
                    hold_cnt_nxt    = HW'(1);
                    last_owner_nxt  = grant_idx_nxt;
                end
            end
            GRANT: begin
                if (req == '0) begin
                    state_nxt       = IDLE;
                    grant_idx_nxt   = '0;
                    grant_valid_nxt = 1'b0;
                    hold_cnt_nxt    = '0;
                end else if (req[grant_idx]) begin
                    if (others != '0 && HOLD_MAX != 0 && hold_cnt >= HOLD_LIM) begin
                        grant_idx_nxt  = pick(others, rr_en, last_owner);
                        hold_cnt_nxt   = HW'(1);
                        last_owner_nxt = grant_idx_nxt;
                    end else if (hold_cnt < HOLD_LIM) begin
                        hold_cnt_nxt = hold_cnt + HW'(1);
                    end
                end else begin
                    // Owner released while others wait: hand over on the same edge.
                    grant_idx_nxt  = pick(req, rr_en, last_owner);
                    hold_cnt_nxt   = HW'(1);
                    last_owner_nxt = grant_idx_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase

        grant_nxt = '0;
        for (int i = 0; i < N; i++) begin
            grant_nxt[i] = grant_valid_nxt && (grant_idx_nxt == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            last_owner  <= IW'(N - 1);
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
        end else begin
            state       <= state_nxt;
            last_owner  <= last_owner_nxt;
            hold_cnt    <= hold_cnt_nxt;
            grant       <= grant_nxt;
            grant_valid <= grant_valid_nxt;
            grant_idx   <= grant_idx_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed vectors for rr_arbiter (N=3, HOLD_MAX=4); expected grants queued per cycle, checked by a monitor.
module tb_rr_arbiter;

    logic       clk;
    logic       res;
    logic       rr_en;
    logic [2:0] req;
    logic [2:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] e;
    logic [1:0] e_idx;

    rr_arbiter #(.N(3), .HOLD_MAX(4)) dut (
        .clk         (clk),
        .res         (res),
        .rr_en       (rr_en),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [2:0] g);
        if (g[1]) return 2'd1;
        if (g[2]) return 2'd2;
        return 2'd0;
    endfunction

    // Monitor: one expected grant per clock edge once stimulus has started.
    always @(posedge clk) begin
        cycle = cycle + 1;
        #1;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            e_idx = idx_of(e);
            checks = checks + 1;
            if (grant !== e) begin
                errors = errors + 1;
                $display("FAIL grant cycle %0d got %b want %b", cycle, grant, e);
            end
            checks = checks + 1;
            if (grant_valid !== (e != 3'b000)) begin
                errors = errors + 1;
                $display("FAIL grant_valid cycle %0d got %b want %b", cycle, grant_valid, (e != 3'b000));
            end
            checks = checks + 1;
            if (grant_idx !== e_idx) begin
                errors = errors + 1;
                $display("FAIL grant_idx cycle %0d got %0d want %0d", cycle, grant_idx, e_idx);
            end
            checks = checks + 1;
            if (!$onehot0(grant)) begin
                errors = errors + 1;
                $display("FAIL onehot cycle %0d got %b want at most one bit", cycle, grant);
            end
        end
    end

    task automatic step(input logic r, input logic rr, input logic [2:0] q, input logic [2:0] exp_g);
        @(negedge clk);
        res   = r;
        rr_en = rr;
        req   = q;
        exp_q.push_back(exp_g);
    endtask

    task automatic step_n(input int n, input logic r, input logic rr, input logic [2:0] q,
                          input logic [2:0] exp_g);
        for (int i = 0; i < n; i++) step(r, rr, q, exp_g);
    endtask

    initial begin
        res   = 1'b1;
        rr_en = 1'b1;
        req   = 3'b111;

        // Reset hold with all requesting.
        step_n(10, 1'b1, 1'b1, 3'b111, 3'b000);

        // Release: first pick is index 0, then rotation every HOLD_MAX cycles.
        step_n(4, 1'b0, 1'b1, 3'b111, 3'b001);
        step_n(4, 1'b0, 1'b1, 3'b111, 3'b010);
        step_n(4, 1'b0, 1'b1, 3'b111, 3'b100);
        step_n(4, 1'b0, 1'b1, 3'b111, 3'b001);

        // Sole requester is never preempted; hand-over on owner drop.
        step_n(20, 1'b0, 1'b1, 3'b100, 3'b100);
        step(1'b0, 1'b1, 3'b000, 3'b000);

        // Hand-over without bubble.
        step(1'b0, 1'b1, 3'b001, 3'b001);
        step(1'b0, 1'b1, 3'b110, 3'b010);
        step(1'b0, 1'b1, 3'b100, 3'b100);
        step(1'b0, 1'b1, 3'b000, 3'b000);

        // Fixed priority: 010 held 4 cycles, then preempted by lowest index.
        step(1'b0, 1'b0, 3'b110, 3'b010);
        step_n(3, 1'b0, 1'b0, 3'b111, 3'b010);
        step(1'b0, 1'b0, 3'b111, 3'b001);

        // rr_en change mid-grant keeps the owner; next pick is round-robin from owner 0.
        step_n(3, 1'b0, 1'b1, 3'b111, 3'b001);
        step(1'b0, 1'b1, 3'b111, 3'b010);

        // Reset mid-grant, then first pick restarts at index 0.
        step(1'b1, 1'b1, 3'b111, 3'b000);
        step(1'b0, 1'b1, 3'b111, 3'b001);
        step(1'b0, 1'b1, 3'b000, 3'b000);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
